data_bus_arbiter: RTL and testbench
===================================

# data_bus_arbiter

Two-master data-bus arbiter and slave decoder that shares the SRAM data port (port 0) and the mtime register block between the core data port (m0) and a DMA/loader master (m1). It sits between the masters and the slaves, and handles three jobs. First, it grants one request per cycle under fixed priority with starvation protection and bounded m1 burst locking. Second, it decodes the address to a slave chip-select. Third, it routes the one-cycle-late response back to the master that issued the request.

## Interface
- MAX_WAIT, 4: number of consecutive cycles m1 may be refused before it gets priority (1..15).
- MAX_BURST, 16: maximum number of consecutive locked m1 grants (1..255).
- clk_i  in  1  clock; all logic is on the rising edge.
- reset_i  in  1  asynchronous reset, active-low.
- mX_req_i  in  1  request from master X (X = 0, 1).
- mX_addr_i  in  32  byte address.
- mX_web_i  in  1  0 = write, 1 = read.
- mX_wmask_i  in  4  byte write mask.
- mX_wdata_i  in  32  write data.
- m1_lock_i  in  1  m1 requests to keep ownership for its next beat.
- mX_gnt_o  out  1  request accepted this cycle (combinational).
- mX_rvalid_o  out  1  response valid (registered).
- mX_rdata_o  out  32  read data; 0 for writes and errors.
- mX_err_o  out  1  the response belongs to an unmapped address.
- sram_csb_o, sram_web_o  out  1 each  SRAM port-0 select and write-enable (both active-low).
- sram_wmask_o  out  4, sram_addr_o  out  11 (addr[12:2]), sram_din_o  out  32, sram_dout_i  in  32.
- mtime_csb_o, mtime_web_o  out  1 each; mtime_addr_o  out  4 (addr[3:0]); mtime_wmask_o  out  4; mtime_wdata_o  out  32; mtime_rdata_i  in  32.

## Operation
- Address decode of the granted address:
  - SRAM if addr[31:13] == 0.
  - mtime if addr[31:4] == 28'h0000200 (0x2000–0x200F).
  - Otherwise unmapped: no slave is selected.
- Slave outputs carry the granted master's web, wmask, wdata and address slice. The selected slave's csb is 0. With no grant, both csb are 1, and web, wmask and data are don't-care.
- FSM states:
  - ARB: normal arbitration.
    - Only one master requesting: that master is granted.
    - Both requesting: m0 wins unless wait_cnt == MAX_WAIT, in which case m1 wins.
    - If m1 is granted with m1_lock_i = 1 and MAX_BURST > 1: go to LOCK with burst_cnt = 1.
  - LOCK: m1 owns the bus; m0_gnt_o = 0.
    - m1_req_i & m1_lock_i & burst_cnt < MAX_BURST: grant m1 and increment burst_cnt.
    - m1_req_i & m1_lock_i & burst_cnt == MAX_BURST: grant m1 only if m0 is not requesting. Otherwise grant m0. Either way, return to ARB.
    - Otherwise: return to ARB and arbitrate as in ARB in the same cycle. m1 cannot re-lock until it is granted again from ARB.
- wait_cnt (4 bit):
  - Increments (saturating at MAX_WAIT) when m1_req_i is high and m1 is not granted.
  - Clears when m1 is granted or m1_req_i is low.
- Response tracking: on every grant, register the owner (m0/m1), the slave (SRAM/mtime/none), and whether the transfer is a read.
  - Next cycle, the owner's rvalid_o = 1 for both reads and writes.
  - rdata_o = sram_dout_i or mtime_rdata_i for reads, and 0 for writes and unmapped accesses.
  - err_o = 1 for unmapped accesses.
  - The non-owner's rvalid, err and rdata stay 0.
- Masters may keep req high across cycles. Each cycle with gnt high is one accepted transfer.

## Timing
- Reset values:
  - gnt, rvalid and err are 0; rdata is 0.
  - sram_csb_o = mtime_csb_o = 1.
  - FSM is in ARB; wait_cnt = burst_cnt = 0; response owner is none.
- Grant and slave selects are combinational from the requests and the registered state in cycle N. The response appears in cycle N+1, so throughput is one transfer per cycle.
- Both slaves must return read data in the cycle after they are selected.
- Reset asserted mid-operation:
  - Pending responses are discarded; no rvalid is produced after reset releases.
  - Slave csb is forced to 1 asynchronously.
- m1 latency bound when m0 requests continuously: at most MAX_WAIT refused cycles, then a grant.
- Lock bound: m0 waits at most MAX_BURST consecutive m1 beats.

## Test plan
- After reset, m0 reads 0x0000_0010 while the SRAM returns 0xDEADBEEF in cycle 1:
  - Cycle 0: m0_gnt = 1, sram_csb = 0, sram_addr = 4.
  - Cycle 1: m0_rvalid = 1, m0_rdata = 0xDEADBEEF, m1_rvalid = 0.
- m0 writes 0x2004 with wmask 4'b0011 and data 0x1234:
  - mtime_csb = 0, mtime_web = 0, mtime_addr = 4, SRAM not selected.
  - Next cycle: rvalid = 1, rdata = 0.
- m1 reads the unmapped address 0x0001_0000: both csb stay 1; next cycle m1_rvalid = 1, m1_err = 1, m1_rdata = 0.
- Both masters request continuously with MAX_WAIT = 4: m0 is granted for 4 cycles, m1 in cycle 5, and the pattern repeats; wait_cnt clears on each m1 grant.
- m1 issues a locked burst of 20 beats with MAX_BURST = 16 and m0 requesting throughout:
  - m1 is granted 16 consecutive beats, then m0 for one cycle.
  - m1 is then refused until starvation or m0 idle; no m0 grant occurs inside the lock.
- reset_i is pulled low in the cycle after a grant: rvalid is 0 and csb is 1 immediately, and no response appears after release.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master data-bus arbiter with SRAM/mtime decode and response routing
//
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-low reset
//   m0_*/m1_* req/addr/web/wmask/wdata  master requests (web: 0 = write, 1 = read)
//   m1_lock_i                      m1 asks to keep the bus for its next beat
//   m0_gnt_o, m1_gnt_o             combinational grant (one accepted transfer per cycle)
//   m0_/m1_ rvalid/rdata/err       registered response, one cycle after the grant
//   sram_*                         SRAM port 0 (csb/web active-low, word address addr[12:2])
//   mtime_*                        mtime register block (addr[3:0])
module data_bus_arbiter #(
   parameter int MAX_WAIT  = 4,
   parameter int MAX_BURST = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        m0_req_i,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_web_i,
   input  logic [3:0]  m0_wmask_i,
   input  logic [31:0] m0_wdata_i,
   input  logic        m1_req_i,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_web_i,
   input  logic [3:0]  m1_wmask_i,
   input  logic [31:0] m1_wdata_i,
   input  logic        m1_lock_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   output logic        m0_err_o,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   output logic        m1_err_o,
   output logic        sram_csb_o,
   output logic        sram_web_o,
   output logic [3:0]  sram_wmask_o,
   output logic [10:0] sram_addr_o,
   output logic [31:0] sram_din_o,
   input  logic [31:0] sram_dout_i,
   output logic        mtime_csb_o,
   output logic        mtime_web_o,
   output logic [3:0]  mtime_addr_o,
   output logic [3:0]  mtime_wmask_o,
   output logic [31:0] mtime_wdata_o,
   input  logic [31:0] mtime_rdata_i
);

   localparam logic [3:0] WAIT_C   = 4'(MAX_WAIT);
   localparam logic [7:0] BURST_C  = 8'(MAX_BURST);
   localparam logic       CAN_LOCK = (MAX_BURST > 1);

   typedef enum logic {ARB, LOCK} state_t;

   state_t      state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic [7:0]  burst_q, burst_d;

   logic        arb_g0, arb_g1;
   logic        gnt0, gnt1, any_gnt;

   logic [31:0] g_addr;
   logic        g_web;
   logic [3:0]  g_wmask;
   logic [31:0] g_wdata;
   logic        sram_hit, mtime_hit;

   logic        rv0_q, rv1_q, rsram_q, rmtime_q, rread_q;
   logic [31:0] resp_data;
   logic        resp_err;

   // Plain fixed-priority pick with starvation override; reused by LOCK when it falls back.
   always_comb begin
      arb_g1 = m1_req_i & (~m0_req_i | (wait_q == WAIT_C));
      arb_g0 = m0_req_i & ~arb_g1;
   end

   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      state_d = state_q;
      burst_d = burst_q;
      case (state_q)
         ARB: begin
            gnt0 = arb_g0;
            gnt1 = arb_g1;
            if (arb_g1 && m1_lock_i && CAN_LOCK) begin
               state_d = LOCK;
               burst_d = 8'd1;
            end
         end
         LOCK: begin
            if (m1_req_i && m1_lock_i) begin
               if (burst_q < BURST_C) begin
                  gnt1    = 1'b1;
                  burst_d = burst_q + 8'd1;
               end else begin
                  // Burst limit reached: a waiting m0 gets the next slot.
                  gnt0    = m0_req_i;
                  gnt1    = ~m0_req_i;
                  state_d = ARB;
                  burst_d = 8'd0;
               end
            end else begin
               gnt0    = arb_g0;
               gnt1    = arb_g1;
               state_d = ARB;
               burst_d = 8'd0;
            end
         end
         default: begin
            state_d = ARB;
            burst_d = 8'd0;
         end
      endcase
      // Reset forces grants (and hence chip selects) inactive without waiting for a clock.
      if (!reset_i) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   always_comb begin
      wait_d = 4'd0;
      if (m1_req_i && !gnt1)
         wait_d = (wait_q == WAIT_C) ? wait_q : wait_q + 4'd1;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= ARB;
         wait_q  <= 4'd0;
         burst_q <= 8'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         burst_q <= burst_d;
      end
   end

   assign any_gnt = gnt0 | gnt1;
   assign g_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
   assign g_web   = gnt1 ? m1_web_i   : m0_web_i;
   assign g_wmask = gnt1 ? m1_wmask_i : m0_wmask_i;
   assign g_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;

   assign sram_hit  = (g_addr[31:13] == 19'd0);
   assign mtime_hit = (g_addr[31:4] == 28'h0000200);

   assign m0_gnt_o      = gnt0;
   assign m1_gnt_o      = gnt1;
   assign sram_csb_o    = ~(any_gnt & sram_hit);
   assign sram_web_o    = g_web;
   assign sram_wmask_o  = g_wmask;
   assign sram_addr_o   = g_addr[12:2];
   assign sram_din_o    = g_wdata;
   assign mtime_csb_o   = ~(any_gnt & mtime_hit);
   assign mtime_web_o   = g_web;
   assign mtime_addr_o  = g_addr[3:0];
   assign mtime_wmask_o = g_wmask;
   assign mtime_wdata_o = g_wdata;

   // Remember who owns the in-flight transfer so next cycle's slave data goes back to it.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
         rsram_q  <= 1'b0;
         rmtime_q <= 1'b0;
         rread_q  <= 1'b0;
      end else begin
         rv0_q    <= gnt0;
         rv1_q    <= gnt1;
         rsram_q  <= any_gnt & sram_hit;
         rmtime_q <= any_gnt & mtime_hit;
         rread_q  <= any_gnt & g_web;
      end
   end

   always_comb begin
      resp_data = 32'd0;
      if (rread_q) begin
         if (rsram_q)
            resp_data = sram_dout_i;
         else if (rmtime_q)
            resp_data = mtime_rdata_i;
      end
   end

   assign resp_err = ~rsram_q & ~rmtime_q;

   assign m0_rvalid_o = rv0_q;
   assign m0_rdata_o  = rv0_q ? resp_data : 32'd0;
   assign m0_err_o    = rv0_q & resp_err;
   assign m1_rvalid_o = rv1_q;
   assign m1_rdata_o  = rv1_q ? resp_data : 32'd0;
   assign m1_err_o    = rv1_q & resp_err;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - directed self-checking bench for data_bus_arbiter
module tb_data_bus_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        m0_req_i, m0_web_i, m1_req_i, m1_web_i, m1_lock_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic [3:0]  m0_wmask_i, m1_wmask_i;
   logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        sram_csb_o, sram_web_o, mtime_csb_o, mtime_web_o;
   logic [3:0]  sram_wmask_o, mtime_addr_o, mtime_wmask_o;
   logic [10:0] sram_addr_o;
   logic [31:0] sram_din_o, sram_dout_i, mtime_wdata_o, mtime_rdata_i;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   data_bus_arbiter #(.MAX_WAIT(4), .MAX_BURST(16)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_web_i(m0_web_i),
      .m0_wmask_i(m0_wmask_i), .m0_wdata_i(m0_wdata_i),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_web_i(m1_web_i),
      .m1_wmask_i(m1_wmask_i), .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i),
      .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
      .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
      .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
      .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i),
      .mtime_csb_o(mtime_csb_o), .mtime_web_o(mtime_web_o), .mtime_addr_o(mtime_addr_o),
      .mtime_wmask_o(mtime_wmask_o), .mtime_wdata_o(mtime_wdata_o), .mtime_rdata_i(mtime_rdata_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are driven and outputs sampled 1 ns later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      m0_req_i  = 1'b0; m0_addr_i = '0; m0_web_i = 1'b1; m0_wmask_i = '0; m0_wdata_i = '0;
      m1_req_i  = 1'b0; m1_addr_i = '0; m1_web_i = 1'b1; m1_wmask_i = '0; m1_wdata_i = '0;
      m1_lock_i = 1'b0;
   endtask

   logic [31:0] dec_addr [5];
   logic        dec_sram [5];
   logic        dec_mtim [5];

   initial begin
      dec_addr[0] = 32'h0000_1FFC; dec_sram[0] = 1'b0; dec_mtim[0] = 1'b1;
      dec_addr[1] = 32'h0000_2000; dec_sram[1] = 1'b1; dec_mtim[1] = 1'b0;
      dec_addr[2] = 32'h0000_200F; dec_sram[2] = 1'b1; dec_mtim[2] = 1'b0;
      dec_addr[3] = 32'h0000_2010; dec_sram[3] = 1'b1; dec_mtim[3] = 1'b1;
      dec_addr[4] = 32'h8000_0000; dec_sram[4] = 1'b1; dec_mtim[4] = 1'b1;

      idle();
      sram_dout_i   = 32'h0;
      mtime_rdata_i = 32'h0;
      reset_i       = 1'b0;
      #12;
      check("rst_m0_gnt", m0_gnt_o, 0);
      check("rst_m1_gnt", m1_gnt_o, 0);
      check("rst_m0_rvalid", m0_rvalid_o, 0);
      check("rst_m1_rvalid", m1_rvalid_o, 0);
      check("rst_m0_err", m0_err_o, 0);
      check("rst_m0_rdata", m0_rdata_o, 0);
      check("rst_sram_csb", sram_csb_o, 1);
      check("rst_mtime_csb", mtime_csb_o, 1);
      @(negedge clk_i);
      reset_i = 1'b1;
      tick();

      // m0 SRAM read
      m0_req_i = 1'b1; m0_addr_i = 32'h10; m0_web_i = 1'b1;
      #1;
      check("rd_m0_gnt", m0_gnt_o, 1);
      check("rd_sram_csb", sram_csb_o, 0);
      check("rd_sram_addr", sram_addr_o, 4);
      check("rd_sram_web", sram_web_o, 1);
      check("rd_mtime_csb", mtime_csb_o, 1);
      tick();
      idle();
      sram_dout_i = 32'hDEAD_BEEF;
      #1;
      check("rd_m0_rvalid", m0_rvalid_o, 1);
      check("rd_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
      check("rd_m0_err", m0_err_o, 0);
      check("rd_m1_rvalid", m1_rvalid_o, 0);
      check("rd_m1_rdata", m1_rdata_o, 0);
      tick();
      check("rd_m0_rvalid_drop", m0_rvalid_o, 0);

      // m0 mtime write
      m0_req_i = 1'b1; m0_addr_i = 32'h2004; m0_web_i = 1'b0;
      m0_wmask_i = 4'b0011; m0_wdata_i = 32'h1234;
      mtime_rdata_i = 32'hCAFE_F00D;
      #1;
      check("wr_m0_gnt", m0_gnt_o, 1);
      check("wr_mtime_csb", mtime_csb_o, 0);
      check("wr_mtime_web", mtime_web_o, 0);
      check("wr_mtime_addr", mtime_addr_o, 4);
      check("wr_mtime_wmask", mtime_wmask_o, 4'b0011);
      check("wr_mtime_wdata", mtime_wdata_o, 32'h1234);
      check("wr_sram_csb", sram_csb_o, 1);
      tick();
      idle();
      #1;
      check("wr_m0_rvalid", m0_rvalid_o, 1);
      check("wr_m0_rdata", m0_rdata_o, 0);
      check("wr_m0_err", m0_err_o, 0);
      tick();

      // m1 unmapped read
      m1_req_i = 1'b1; m1_addr_i = 32'h0001_0000; m1_web_i = 1'b1;
      sram_dout_i = 32'h5555_AAAA;
      #1;
      check("um_m1_gnt", m1_gnt_o, 1);
      check("um_sram_csb", sram_csb_o, 1);
      check("um_mtime_csb", mtime_csb_o, 1);
      tick();
      idle();
      #1;
      check("um_m1_rvalid", m1_rvalid_o, 1);
      check("um_m1_err", m1_err_o, 1);
      check("um_m1_rdata", m1_rdata_o, 0);
      check("um_m0_rvalid", m0_rvalid_o, 0);
      tick();

      // m1 mtime read
      m1_req_i = 1'b1; m1_addr_i = 32'h2008; m1_web_i = 1'b1;
      tick();
      idle();
      #1;
      check("mt_m1_rvalid", m1_rvalid_o, 1);
      check("mt_m1_rdata", m1_rdata_o, 32'hCAFE_F00D);
      check("mt_m1_err", m1_err_o, 0);
      check("mt_m0_rdata", m0_rdata_o, 0);
      tick();

      // decode boundaries
      for (int i = 0; i < 5; i++) begin
         m0_req_i = 1'b1; m0_addr_i = dec_addr[i]; m0_web_i = 1'b1;
         #1;
         check($sformatf("dec%0d_sram_csb", i), sram_csb_o, dec_sram[i]);
         check($sformatf("dec%0d_mtime_csb", i), mtime_csb_o, dec_mtim[i]);
         tick();
      end
      idle();
      tick();

      // both request continuously: m1 every 5th cycle
      for (int k = 0; k < 10; k++) begin
         m0_req_i = 1'b1; m0_addr_i = 32'h100; m1_req_i = 1'b1; m1_addr_i = 32'h200;
         #1;
         check($sformatf("starve%0d_m1_gnt", k), m1_gnt_o, (k % 5 == 4));
         check($sformatf("starve%0d_m0_gnt", k), m0_gnt_o, (k % 5 != 4));
         if (k % 5 == 4)
            check($sformatf("starve%0d_sram_addr", k), sram_addr_o, 11'h80);
         tick();
      end
      idle();
      tick();

      // locked m1 burst against continuous m0
      for (int k = 0; k < 25; k++) begin
         m0_req_i = 1'b1; m0_addr_i = 32'h100;
         m1_req_i = 1'b1; m1_addr_i = 32'h200; m1_lock_i = 1'b1;
         #1;
         check($sformatf("lock%0d_m1_gnt", k), m1_gnt_o, ((k >= 4 && k <= 19) || k == 24));
         check($sformatf("lock%0d_m0_gnt", k), m0_gnt_o, !((k >= 4 && k <= 19) || k == 24));
         tick();
      end
      idle();
      #1;
      check("lock_exit_m1_gnt", m1_gnt_o, 0);
      check("lock_exit_m0_gnt", m0_gnt_o, 0);
      tick();
      tick();

      // reset in the cycle after a grant
      m0_req_i = 1'b1; m0_addr_i = 32'h10; m0_web_i = 1'b1;
      tick();
      reset_i = 1'b0;
      #1;
      check("mrst_m0_rvalid", m0_rvalid_o, 0);
      check("mrst_m0_gnt", m0_gnt_o, 0);
      check("mrst_sram_csb", sram_csb_o, 1);
      idle();
      @(negedge clk_i);
      reset_i = 1'b1;
      tick();
      check("mrst_post_m0_rvalid", m0_rvalid_o, 0);
      check("mrst_post_m1_rvalid", m1_rvalid_o, 0);
      tick();
      check("mrst_post2_m0_rvalid", m0_rvalid_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
